// File: rtl/i2c_top.sv
// I2C master and single-register I2C slave sharing one internal bus, used as a framing loopback.
// Optional macro I2C_ADDR_CHECK_EN: the slave ACKs only SLAVE_ADDR and the master goes to STOP on NACK.
module i2c_top #(
   parameter int         CLK_DIV    = 4,
   parameter logic [6:0] SLAVE_ADDR = 7'd8,
   parameter logic [7:0] SLAVE_INIT = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       rw,
   input  logic [7:0] data_in,
   input  logic [6:0] address,
   output logic       valid,
   output logic [7:0] data_out,
   output logic       scl_out,
   output logic       sda_out
);
   localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_ADDR, S_ACK1, S_DATA, S_ACK2, S_STOP
   } state_t;

   state_t        state_q;
   logic [DW-1:0] div_q;
   logic [1:0]    qtr_q;
   logic [2:0]    bit_q;
   logic          rw_q;
   logic [6:0]    addr_q;
   logic [7:0]    wdata_q;
   logic [7:0]    rd_q;
   logic          scl_q;
   logic          sda_q;
   logic          valid_q;
   logic [7:0]    data_out_q;
   logic [7:0]    slv_reg_q;
   logic [7:0]    slv_sh_q;
   logic          slv_rw_q;
`ifdef I2C_ADDR_CHECK_EN
   logic          ack_q;
   logic          nack_q;
`endif

   logic       m_scl_d;
   logic       m_sda_d;
   logic       s_sda_d;
   logic       bus_sda_d;
   logic       bit_scl;
   logic       sample_pt;
   logic       slot_end;
   logic [7:0] tx_addr;
   logic [2:0] msb_idx;

   assign bit_scl   = (qtr_q == 2'd1) || (qtr_q == 2'd2);
   assign sample_pt = (qtr_q == 2'd1) && (div_q == '0);
   assign slot_end  = (qtr_q == 2'd3) && (div_q == DIV_LAST);
   assign tx_addr   = {addr_q, rw_q};
   assign msb_idx   = 3'd7 - bit_q;

   // Both ends drive open-drain style: the bus is the AND of master and slave.
   always_comb begin
      m_scl_d = 1'b1;
      m_sda_d = 1'b1;
      s_sda_d = 1'b1;
      case (state_q)
         S_START: begin
            m_scl_d = (qtr_q < 2'd2);
            m_sda_d = (qtr_q == 2'd0);
         end
         S_ADDR: begin
            m_scl_d = bit_scl;
            m_sda_d = tx_addr[msb_idx];
         end
         S_ACK1: begin
            m_scl_d = bit_scl;
`ifdef I2C_ADDR_CHECK_EN
            s_sda_d = (slv_sh_q[7:1] == SLAVE_ADDR) ? 1'b0 : 1'b1;
`else
            s_sda_d = 1'b0;
`endif
         end
         S_DATA: begin
            m_scl_d = bit_scl;
            m_sda_d = rw_q ? 1'b1 : wdata_q[msb_idx];
            s_sda_d = slv_rw_q ? slv_reg_q[msb_idx] : 1'b1;
         end
         S_ACK2: begin
            m_scl_d = bit_scl;
            s_sda_d = slv_rw_q;
         end
         S_STOP: begin
            m_scl_d = (qtr_q != 2'd0);
            m_sda_d = (qtr_q >= 2'd2);
         end
         default: ;
      endcase
      bus_sda_d = m_sda_d & s_sda_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         qtr_q      <= 2'd0;
         bit_q      <= 3'd0;
         rw_q       <= 1'b0;
         addr_q     <= 7'd0;
         wdata_q    <= 8'h00;
         rd_q       <= 8'h00;
         scl_q      <= 1'b1;
         sda_q      <= 1'b1;
         valid_q    <= 1'b0;
         data_out_q <= 8'h00;
         slv_reg_q  <= SLAVE_INIT;
         slv_sh_q   <= 8'h00;
         slv_rw_q   <= 1'b0;
`ifdef I2C_ADDR_CHECK_EN
         ack_q      <= 1'b0;
         nack_q     <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
         scl_q   <= m_scl_d;
         sda_q   <= bus_sda_d;
         if (state_q == S_IDLE) begin
            if (ena) begin
               state_q <= S_START;
               rw_q    <= rw;
               addr_q  <= address;
               wdata_q <= data_in;
               div_q   <= '0;
               qtr_q   <= 2'd0;
               bit_q   <= 3'd0;
`ifdef I2C_ADDR_CHECK_EN
               nack_q  <= 1'b0;
`endif
            end
         end else begin
            if (div_q == DIV_LAST) begin
               div_q <= '0;
               qtr_q <= qtr_q + 2'd1;
            end else begin
               div_q <= div_q + DW'(1);
            end

            if (sample_pt) begin
               case (state_q)
                  S_ADDR: begin
                     slv_sh_q <= {slv_sh_q[6:0], bus_sda_d};
                     if (bit_q == 3'd7) slv_rw_q <= bus_sda_d;
                  end
                  S_DATA: begin
                     slv_sh_q <= {slv_sh_q[6:0], bus_sda_d};
                     rd_q     <= {rd_q[6:0], bus_sda_d};
                  end
`ifdef I2C_ADDR_CHECK_EN
                  S_ACK1: ack_q <= bus_sda_d;
`endif
                  default: ;
               endcase
            end

            if (slot_end) begin
               case (state_q)
                  S_START: begin
                     state_q <= S_ADDR;
                     bit_q   <= 3'd0;
                  end
                  S_ADDR: begin
                     if (bit_q == 3'd7) begin
                        state_q <= S_ACK1;
                        bit_q   <= 3'd0;
                     end else begin
                        bit_q <= bit_q + 3'd1;
                     end
                  end
                  S_ACK1: begin
`ifdef I2C_ADDR_CHECK_EN
                     if (ack_q) begin
                        state_q <= S_STOP;
                        nack_q  <= 1'b1;
                     end else begin
                        state_q <= S_DATA;
                     end
`else
                     state_q <= S_DATA;
`endif
                  end
                  S_DATA: begin
                     if (bit_q == 3'd7) begin
                        state_q <= S_ACK2;
                        bit_q   <= 3'd0;
                     end else begin
                        bit_q <= bit_q + 3'd1;
                     end
                  end
                  S_ACK2: begin
                     state_q <= S_STOP;
                     if (!slv_rw_q) slv_reg_q <= slv_sh_q;
                  end
                  S_STOP: begin
                     state_q <= S_IDLE;
`ifdef I2C_ADDR_CHECK_EN
                     if (!nack_q) begin
                        valid_q <= 1'b1;
                        if (rw_q) data_out_q <= rd_q;
                     end
`else
                     valid_q <= 1'b1;
                     if (rw_q) data_out_q <= rd_q;
`endif
                  end
                  default: state_q <= S_IDLE;
               endcase
            end
         end
      end
   end

   assign valid    = valid_q;
   assign data_out = data_out_q;
   assign scl_out  = scl_q;
   assign sda_out  = sda_q;
endmodule

// File: tb/tb_i2c_top.sv
// Directed bench for i2c_top: frame shape, bit values, valid timing, reset and address-check behaviour.
module tb_i2c_top;
   localparam int D     = 4;
   localparam int FRAME = 80 * D;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       rw = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [6:0] address = 7'd0;
   logic       valid;
   logic [7:0] data_out;
   logic       scl_out;
   logic       sda_out;

   int   vectors = 0;
   int   miscompares = 0;
   logic slot_sda [0:19];
   int   valid_count;
   int   valid_cycle;
   int   shape_err;

   always #5 clk = ~clk;

   i2c_top #(.CLK_DIV(D), .SLAVE_ADDR(7'd8), .SLAVE_INIT(8'hA5)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .rw       (rw),
      .data_in  (data_in),
      .address  (address),
      .valid    (valid),
      .data_out (data_out),
      .scl_out  (scl_out),
      .sda_out  (sda_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Observes one frame; cycle c is sampled 1 time unit after edge T0+c.
   task automatic run_frame(input logic f_rw, input logic [7:0] f_din, input logic [6:0] f_addr,
                            input bit skip_t0, input bit hold, input bit scramble, input int nslots);
      int   p, s, q, f;
      logic es, ed;
      if (!skip_t0) begin
         rw = f_rw; data_in = f_din; address = f_addr; ena = 1'b1;
         @(posedge clk); #1;
      end
      if (!hold) ena = 1'b0;
      valid_count = 0; valid_cycle = -1; shape_err = 0;
      for (int i = 0; i < 20; i++) slot_sda[i] = 1'bx;
      for (int c = 1; c <= FRAME + 1; c++) begin
         @(posedge clk); #1;
         if (scramble && c == 50) begin
            address = ~address; data_in = ~data_in; rw = ~rw;
         end
         p = c - 1; s = p / (4 * D); q = (p % (4 * D)) / D; f = p % D;
         if (valid === 1'b1) begin
            valid_count++;
            valid_cycle = c;
         end
         if (s >= nslots) begin
            es = 1'b1; ed = 1'b1;
         end else if (s == 0) begin
            es = (q < 2); ed = (q == 0);
         end else if (s == nslots - 1) begin
            es = (q != 0); ed = (q >= 2);
         end else begin
            if (q == 1 && f == 0) slot_sda[s] = sda_out;
            es = (q == 1 || q == 2);
            ed = (q == 0) ? sda_out : slot_sda[s];
         end
         if (scl_out !== es || sda_out !== ed) shape_err++;
      end
      $display("frame rw=%0d addr=%02h din=%02h valid_count=%0d valid_cycle=%0d data_out=%02h",
               f_rw, f_addr, f_din, valid_count, valid_cycle, data_out);
   endtask

   task automatic check_frame(input string name, input logic [7:0] exp_addr, input logic exp_ack1,
                              input bit full, input logic [7:0] exp_data, input logic exp_ack2,
                              input int exp_valid);
      logic [7:0] ab, db;
      for (int i = 0; i < 8; i++) begin
         ab[7-i] = slot_sda[1+i];
         db[7-i] = slot_sda[10+i];
      end
      chk({name, ".shape"}, 32'(shape_err), 32'd0);
      chk({name, ".addr"}, {24'd0, ab}, {24'd0, exp_addr});
      chk({name, ".ack1"}, {31'd0, slot_sda[9]}, {31'd0, exp_ack1});
      if (full) begin
         chk({name, ".data"}, {24'd0, db}, {24'd0, exp_data});
         chk({name, ".ack2"}, {31'd0, slot_sda[18]}, {31'd0, exp_ack2});
      end
      chk({name, ".valid_count"}, 32'(valid_count), 32'(exp_valid));
      if (exp_valid == 1) chk({name, ".valid_cycle"}, 32'(valid_cycle), 32'(FRAME));
   endtask

   initial begin
      int vseen;
      // Reset
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst.scl", {31'd0, scl_out}, 32'd1);
      chk("rst.sda", {31'd0, sda_out}, 32'd1);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("idle.scl", {31'd0, scl_out}, 32'd1);
      chk("idle.sda", {31'd0, sda_out}, 32'd1);
      chk("idle.valid", {31'd0, valid}, 32'd0);
      chk("idle.data_out", {24'd0, data_out}, 32'h00);

      // Read after reset, then a back-to-back read with ena held high
      run_frame(1'b1, 8'h0A, 7'd8, 1'b0, 1'b1, 1'b0, 20);
      check_frame("rd1", 8'h11, 1'b0, 1'b1, 8'hA5, 1'b1, 1);
      chk("rd1.data_out", {24'd0, data_out}, 32'hA5);
      run_frame(1'b1, 8'h0A, 7'd8, 1'b1, 1'b0, 1'b0, 20);
      check_frame("rd2", 8'h11, 1'b0, 1'b1, 8'hA5, 1'b1, 1);

      // Write then read
      run_frame(1'b0, 8'h3C, 7'd8, 1'b0, 1'b0, 1'b0, 20);
      check_frame("wr1", 8'h10, 1'b0, 1'b1, 8'h3C, 1'b0, 1);
      chk("wr1.data_out", {24'd0, data_out}, 32'hA5);
      run_frame(1'b1, 8'h00, 7'd8, 1'b0, 1'b0, 1'b0, 20);
      check_frame("rd3", 8'h11, 1'b0, 1'b1, 8'h3C, 1'b1, 1);
      chk("rd3.data_out", {24'd0, data_out}, 32'h3C);

      // Inputs disturbed mid-frame must not affect the latched write
      run_frame(1'b0, 8'hC3, 7'd8, 1'b0, 1'b0, 1'b1, 20);
      check_frame("wr2", 8'h10, 1'b0, 1'b1, 8'hC3, 1'b0, 1);
      run_frame(1'b1, 8'h00, 7'd8, 1'b0, 1'b0, 1'b0, 20);
      check_frame("rd4", 8'h11, 1'b0, 1'b1, 8'hC3, 1'b1, 1);
      chk("rd4.data_out", {24'd0, data_out}, 32'hC3);

      // Read from a foreign address
`ifdef I2C_ADDR_CHECK_EN
      run_frame(1'b1, 8'h00, 7'h22, 1'b0, 1'b0, 1'b0, 11);
      check_frame("bad", 8'h45, 1'b1, 1'b0, 8'h00, 1'b1, 0);
`else
      run_frame(1'b1, 8'h00, 7'h22, 1'b0, 1'b0, 1'b0, 20);
      check_frame("bad", 8'h45, 1'b0, 1'b1, 8'hC3, 1'b1, 1);
`endif
      chk("bad.data_out", {24'd0, data_out}, 32'hC3);

      // Reset during the DATA phase of a write
      rw = 1'b0; data_in = 8'h5A; address = 7'd8; ena = 1'b1;
      @(posedge clk); #1;
      ena = 1'b0;
      repeat (12 * 4 * D) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("abort.scl", {31'd0, scl_out}, 32'd1);
      chk("abort.sda", {31'd0, sda_out}, 32'd1);
      chk("abort.valid", {31'd0, valid}, 32'd0);
      chk("abort.data_out", {24'd0, data_out}, 32'h00);
      @(posedge clk); #1;
      rst_n = 1'b1;
      vseen = 0;
      for (int c = 0; c < FRAME + 40; c++) begin
         @(posedge clk); #1;
         if (valid === 1'b1 || scl_out !== 1'b1) vseen++;
      end
      chk("abort.quiet", 32'(vseen), 32'd0);
      run_frame(1'b1, 8'h00, 7'd8, 1'b0, 1'b0, 1'b0, 20);
      check_frame("rd5", 8'h11, 1'b0, 1'b1, 8'hA5, 1'b1, 1);
      chk("rd5.data_out", {24'd0, data_out}, 32'hA5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
